// File: rtl/psum_load_ctrl_if.sv
// Psum reload bus: GLB read port on one side, PE-array psum stream on the other.
// The controller takes the master modport; the GLB and PE array together form the slave.
interface psum_load_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              o_psum_glb_re;
    logic [15:0]       o_psum_glb_ra;
    logic [DATA_W-1:0] i_psum_glb_rd;
    logic              o_psum_valid;
    logic [DATA_W-1:0] o_psum_data;
    logic              i_psum_ready;

    modport master (
        output o_psum_glb_re, o_psum_glb_ra, o_psum_valid, o_psum_data,
        input  i_psum_glb_rd, i_psum_ready
    );

    modport slave (
        input  o_psum_glb_re, o_psum_glb_ra, o_psum_valid, o_psum_data,
        output i_psum_glb_rd, i_psum_ready
    );
endinterface

// File: rtl/psum_load_ctrl.sv
// Reloads one pass of partial sums from the GLB and streams them to the PE array.
// A 2-entry skid FIFO absorbs PE backpressure across the 1-cycle GLB read latency.
module psum_load_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic [5:0]        i_iter_cnt,
    input  logic [6:0]        i_layer_m,
    input  logic [2:0]        i_layer_n,
    input  logic [4:0]        i_layer_p,
    input  logic [4:0]        i_layer_e,
    input  logic [2:0]        i_layer_q,
    input  logic [2:0]        i_layer_r,
    input  logic [3:0]        i_layer_s,
    input  logic [2:0]        i_layer_t,
    psum_load_ctrl_if.master  bus,
    output logic              o_busy,
    output logic              o_load_done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic [4:0]        cnt_p;
    logic [4:0]        cnt_e;
    logic              inflight;
    logic [1:0]        occ;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] fifo_mem [2];

    logic              empty_cfg;
    logic              last_p;
    logic              last_rd;
    logic              re;
    logic              push;
    logic              pop;
    logic [31:0]       addr_full;

    // Only p and e shape the address walk; the rest are carried for the shared layer bus.
    logic unused_layer;
    assign unused_layer = ^{i_layer_m, i_layer_n, i_layer_q, i_layer_r, i_layer_s, i_layer_t};

    assign empty_cfg = (i_layer_p == 5'd0) || (i_layer_e == 5'd0);
    assign last_p    = (cnt_p == i_layer_p - 5'd1);
    assign last_rd   = last_p && (cnt_e == i_layer_e - 5'd1);

    // Same layout as the store side so a pass reloads exactly what the previous one wrote.
    always_comb begin
        addr_full = 32'(i_layer_e) * 32'(i_layer_e) * 32'(i_layer_p)
                  + 32'(cnt_p) * 32'(i_layer_e) * 32'(i_layer_e)
                  + 32'(cnt_e) * 32'(i_layer_e)
                  + 32'(i_iter_cnt);
    end

    // A read may only issue when its data is guaranteed a free FIFO slot on arrival.
    assign re   = (state == ST_LOAD) && ((occ == 2'd0) || (occ == 2'd1 && !inflight));
    assign push = inflight;
    assign pop  = bus.o_psum_valid && bus.i_psum_ready;

    assign bus.o_psum_glb_re = re;
    assign bus.o_psum_glb_ra = addr_full[15:0];
    assign bus.o_psum_valid  = (occ != 2'd0);
    assign bus.o_psum_data   = fifo_mem[rd_ptr];
    assign o_busy            = (state != ST_IDLE);
    assign o_load_done       = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            inflight <= re;
            case (state)
                ST_IDLE: begin
                    if (i_load_start) state <= empty_cfg ? ST_DONE : ST_LOAD;
                end
                ST_LOAD: begin
                    if (re && last_rd) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (occ == 2'd0 && !inflight) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p is the inner loop; both counters wrap to zero after the final read.
    always_ff @(posedge i_clk) begin
        if (i_rst || state == ST_IDLE) begin
            cnt_p <= 5'd0;
            cnt_e <= 5'd0;
        end else if (re) begin
            if (last_rd) begin
                cnt_p <= 5'd0;
                cnt_e <= 5'd0;
            end else if (last_p) begin
                cnt_p <= 5'd0;
                cnt_e <= cnt_e + 5'd1;
            end else begin
                cnt_p <= cnt_p + 5'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.i_psum_glb_rd;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_load_ctrl.sv
// Directed bench for psum_load_ctrl: queue-based pass model checked every cycle,
// plus literal address/data sequences that pin the model.
module tb_psum_load_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, ready;
    logic [5:0] iter;
    logic [6:0] lm;
    logic [2:0] ln, lq, lr, lt;
    logic [3:0] ls;
    logic [4:0] lp, le;
    logic       busy, done;
    logic       chk_en = 1'b0;

    int n_chk = 0, n_fail = 0, n_done = 0;
    logic [15:0] ra_log[$];
    logic [15:0] out_log[$];

    always #5 clk = ~clk;

    psum_load_ctrl_if #(.DATA_W(16)) bus();
    assign bus.i_psum_ready = ready;

    psum_load_ctrl #(.DATA_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_load_start(start), .i_iter_cnt(iter),
        .i_layer_m(lm), .i_layer_n(ln), .i_layer_p(lp), .i_layer_e(le),
        .i_layer_q(lq), .i_layer_r(lr), .i_layer_s(ls), .i_layer_t(lt),
        .bus(bus), .o_busy(busy), .o_load_done(done)
    );

    // GLB returns the address as data, one cycle after the read enable.
    always @(posedge clk) bus.i_psum_glb_rd <= bus.o_psum_glb_re ? bus.o_psum_glb_ra : 16'hdead;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] addr_of(input int idx);
        int pp, ee, cp, ce;
        pp = int'(lp); ee = int'(le);
        cp = (pp == 0) ? 0 : idx % pp;
        ce = (pp == 0) ? 0 : idx / pp;
        return 16'(ee * ee * pp + cp * ee * ee + ce * ee + int'(iter));
    endfunction

    // Pass model: read index, expected buffer contents, one pending read.
    int          m_load = 0, m_done = 0, m_issued = 0, m_total = 0, m_inf = 0;
    logic [15:0] m_inf_addr;
    logic [15:0] m_q[$];

    function automatic bit m_re();
        return (m_load != 0) && (m_issued < m_total) && (m_q.size() + m_inf < 2);
    endfunction

    always @(posedge clk) begin
        bit          re_now, pop_now, fin;
        logic [15:0] a;
        if (rst) begin
            m_load = 0; m_done = 0; m_issued = 0; m_total = 0; m_inf = 0;
            m_q.delete();
        end else begin
            re_now  = m_re();
            a       = addr_of(m_issued);
            pop_now = (m_q.size() > 0) && ready;
            fin     = (m_load != 0) && (m_issued == m_total) && (m_q.size() == 0) && (m_inf == 0);
            if (pop_now) void'(m_q.pop_front());
            if (m_inf != 0) m_q.push_back(m_inf_addr);
            m_inf      = re_now ? 1 : 0;
            m_inf_addr = a;
            if (re_now) m_issued++;
            if (m_done != 0) m_done = 0;
            else if (fin) begin m_load = 0; m_done = 1; end
            else if (m_load == 0 && start) begin
                if (lp == 5'd0 || le == 5'd0) m_done = 1;
                else begin m_load = 1; m_issued = 0; m_total = int'(lp) * int'(le); end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("re", 32'(bus.o_psum_glb_re), 32'(m_re()));
            chk("valid", 32'(bus.o_psum_valid), 32'(m_q.size() > 0));
            chk("busy", 32'(busy), 32'((m_load | m_done) != 0));
            chk("done", 32'(done), 32'(m_done));
            if (m_re()) chk("ra", 32'(bus.o_psum_glb_ra), 32'(addr_of(m_issued)));
            else if (m_load == 0 && m_done == 0) chk("ra_idle", 32'(bus.o_psum_glb_ra), 32'(addr_of(0)));
            if (m_q.size() > 0) chk("data", 32'(bus.o_psum_data), 32'(m_q[0]));
        end
        if (bus.o_psum_glb_re) ra_log.push_back(bus.o_psum_glb_ra);
        if (bus.o_psum_valid && ready) out_log.push_back(bus.o_psum_data);
        if (done) n_done++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_pass(input int p, input int e, input int it, input int stall);
        int cyc, d0;
        lp = 5'(p); le = 5'(e); iter = 6'(it);
        ra_log.delete(); out_log.delete();
        d0 = n_done;
        start = 1'b1; ready = 1'b1;
        tick(1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 5000) begin
            ready = !(stall >= 0 && cyc >= stall && cyc < stall + 20);
            if (stall >= 0 && cyc == stall + 10) begin
                chk("stall_valid", 32'(bus.o_psum_valid), 32'd1);
                chk("stall_re", 32'(bus.o_psum_glb_re), 32'd0);
            end
            tick(1);
            cyc++;
        end
        chk("done_timeout", 32'(cyc < 5000), 32'd1);
        ready = 1'b1;
        tick(2);
        chk("done_pulses", 32'(n_done - d0), 32'd1);
    endtask

    initial begin
        logic [15:0] exp0 [6];
        logic [15:0] exp5 [6];
        exp0 = '{16'd18, 16'd27, 16'd21, 16'd30, 16'd24, 16'd33};
        exp5 = '{16'd23, 16'd32, 16'd26, 16'd35, 16'd29, 16'd38};
        rst = 1'b1; start = 1'b0; ready = 1'b1; iter = 6'd0;
        lm = 7'd1; ln = 3'd1; lq = 3'd1; lr = 3'd1; ls = 4'd1; lt = 3'd1;
        lp = 5'd2; le = 5'd3;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("rst_re", 32'(bus.o_psum_glb_re), 32'd0);
        chk("rst_valid", 32'(bus.o_psum_valid), 32'd0);
        chk("rst_data", 32'(bus.o_psum_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ra", 32'(bus.o_psum_glb_ra), 32'd18);
        rst = 1'b0;
        tick(1);

        run_pass(2, 3, 0, -1);
        chk("p2e3_nreads", 32'(ra_log.size()), 32'd6);
        chk("p2e3_nout", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < ra_log.size() && i < out_log.size(); i++) begin
            chk("p2e3_addr", 32'(ra_log[i]), 32'(exp0[i]));
            chk("p2e3_out", 32'(out_log[i]), 32'(exp0[i]));
        end

        run_pass(2, 3, 5, -1);
        chk("iter5_nout", 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            chk("iter5_out", 32'(out_log[i]), 32'(exp5[i]));

        run_pass(4, 3, 1, 4);
        chk("stall_nout", 32'(out_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < out_log.size(); i++)
            chk("stall_order", 32'(out_log[i]), 32'(addr_of(i)));

        run_pass(31, 31, 63, -1);
        chk("big_nout", 32'(out_log.size()), 32'd961);
        if (ra_log.size() == 961) chk("big_last_addr", 32'(ra_log[960]), 32'd59614);
        else chk("big_nreads", 32'(ra_log.size()), 32'd961);

        lp = 5'd0; le = 5'd3; iter = 6'd0;
        ra_log.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("p0_done", 32'(done), 32'd1);
        chk("p0_busy", 32'(busy), 32'd1);
        tick(1);
        chk("p0_busy_off", 32'(busy), 32'd0);
        chk("p0_done_off", 32'(done), 32'd0);
        chk("p0_reads", 32'(ra_log.size()), 32'd0);

        lp = 5'd2; le = 5'd3; iter = 6'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", 32'(bus.o_psum_valid), 32'd0);
        chk("mid_rst_re", 32'(bus.o_psum_glb_re), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ra", 32'(bus.o_psum_glb_ra), 32'd18);
        rst = 1'b0;
        tick(1);
        run_pass(2, 3, 0, -1);
        chk("after_rst_nout", 32'(out_log.size()), 32'd6);
        if (out_log.size() > 0) chk("after_rst_first", 32'(out_log[0]), 32'd18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
